trivium_ks_ctrl: RTL and testbench

//  Sequencer for the Trivium keystream core (80b key/IV, 128b block, Krdy/Drdy/BSY/Kvld/Dvld

---
 rtl/trivium_pkg.sv | 9 +
 rtl/trivium_ks_ctrl_if.sv | 19 +
 rtl/trivium_ks_serializer.sv | 52 +++++
 rtl/trivium_ks_ctrl.sv | 114 +++++++++++
 tb/tb_trivium_ks_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trivium_pkg.sv
// Shared widths, state encoding and core timing for the Trivium keystream sequencer.
package trivium_pkg;
  localparam int KEY_W        = 80;
  localparam int IV_W         = 80;
  localparam int BLK_W        = 128;
  localparam int TRIV_BLK_CYC = 1283;

  typedef enum logic [2:0] {IDLE, KEY, KWAIT, IV, BUSY, DRAIN, ABORT} st_e;
endpackage

// File: rtl/trivium_ks_ctrl_if.sv
// Host-side bundle: key/IV command channel in, keystream word stream out.
interface trivium_ks_ctrl_if #(parameter int WORD_W = 32);
  import trivium_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rekey;
  logic [KEY_W-1:0]  cmd_key;
  logic [IV_W-1:0]   cmd_iv;
  logic              ks_valid;
  logic              ks_ready;
  logic [WORD_W-1:0] ks_data;
  logic              ks_last;

  modport master (output cmd_valid, cmd_rekey, cmd_key, cmd_iv, ks_ready,
                  input  cmd_ready, ks_valid, ks_data, ks_last);
  modport slave  (input  cmd_valid, cmd_rekey, cmd_key, cmd_iv, ks_ready,
                  output cmd_ready, ks_valid, ks_data, ks_last);
endinterface

// File: rtl/trivium_ks_serializer.sv
// Splits one 128b keystream block into WORD_W words, LS word first, valid/ready out.
module trivium_ks_serializer
  import trivium_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              load,
  input  logic [BLK_W-1:0]  din,
  output logic              valid,
  input  logic              ready,
  output logic [WORD_W-1:0] data,
  output logic              last,
  output logic              done
);
  localparam int NW    = BLK_W / WORD_W;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IDX_W-1:0] PEN = IDX_W'((NW > 1) ? NW - 2 : 0);

  logic [BLK_W-1:0] buf_q;
  logic [IDX_W-1:0] idx;
  logic             xfer;

  assign xfer = valid & ready;
  assign done = xfer & last;
  // Shifting keeps the current word in the low bits, so ks_data is a plain flop output.
  assign data = buf_q[WORD_W-1:0];

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      buf_q <= '0;
      idx   <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      buf_q <= din;
      idx   <= '0;
      valid <= 1'b1;
      last  <= (NW == 1);
    end else if (xfer) begin
      if (last) begin
        valid <= 1'b0;
        last  <= 1'b0;
      end else begin
        buf_q <= buf_q >> WORD_W;
        idx   <= idx + 1'b1;
        last  <= (idx == PEN);
      end
    end
  end
endmodule

// File: rtl/trivium_ks_ctrl.sv
// Trivium core sequencer: one key/IV command -> core load pulses -> 128b block -> word stream.
module trivium_ks_ctrl
  import trivium_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 2047,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  trivium_ks_ctrl_if.slave  bus,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  blk_cnt,
  output logic [KEY_W-1:0]  core_Kin,
  output logic [IV_W-1:0]   core_Din,
  output logic              core_Krdy,
  output logic              core_Drdy,
  output logic              core_EncDec,
  output logic              core_EN,
  input  logic              core_BSY,
  input  logic              core_Kvld,
  input  logic              core_Dvld,
  input  logic [BLK_W-1:0]  core_Dout
);
  // Counter is wide enough for a real core block even when TIMEOUT is set small.
  localparam int WD_MAX = (TIMEOUT > TRIV_BLK_CYC) ? TIMEOUT : TRIV_BLK_CYC;
  localparam int WD_W   = $clog2(WD_MAX + 1);

  st_e             st, nxt;
  logic [WD_W-1:0] wd;
  logic            key_ok, cmd_ready_q, accept, wd_exp;
  logic            ser_load, ser_done, ser_valid, ser_last;
  logic [WORD_W-1:0] ser_data;

  // Completion is taken only from Kvld/Dvld; BSY is informational.
  logic unused_bsy;
  assign unused_bsy = core_BSY;

  assign accept      = bus.cmd_valid & cmd_ready_q;
  assign wd_exp      = (wd == WD_W'(TIMEOUT));
  assign ser_load    = (st == BUSY) & core_Dvld;
  assign core_EncDec = 1'b0;

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.ks_valid  = ser_valid;
  assign bus.ks_data   = ser_data;
  assign bus.ks_last   = ser_last;

  always_comb begin
    nxt = st;
    case (st)
      IDLE:    if (accept) nxt = (bus.cmd_rekey || !key_ok) ? KEY : IV;
      KEY:     nxt = KWAIT;
      KWAIT:   if (core_Kvld) nxt = IV;
               else if (wd_exp) nxt = ABORT;
      IV:      nxt = BUSY;
      // Dvld is checked first so a block landing on the last watchdog cycle is kept.
      BUSY:    if (core_Dvld) nxt = DRAIN;
               else if (wd_exp) nxt = ABORT;
      DRAIN:   if (ser_done) nxt = IDLE;
      ABORT:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      st          <= IDLE;
      cmd_ready_q <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      key_ok      <= 1'b0;
      blk_cnt     <= '0;
      wd          <= '0;
      core_Kin    <= '0;
      core_Din    <= '0;
      core_Krdy   <= 1'b0;
      core_Drdy   <= 1'b0;
      core_EN     <= 1'b0;
    end else begin
      st          <= nxt;
      cmd_ready_q <= (nxt == IDLE);
      busy        <= (nxt != IDLE);
      core_Krdy   <= (nxt == KEY);
      core_Drdy   <= (nxt == IV);
      core_EN     <= 1'b1;
      wd          <= (st == KWAIT || st == BUSY) ? wd + 1'b1 : '0;
      if (accept) begin
        core_Kin <= bus.cmd_key;
        core_Din <= bus.cmd_iv;
        err      <= 1'b0;
      end
      if (st == KWAIT && core_Kvld) key_ok <= 1'b1;
      if (st == ABORT) begin
        err    <= 1'b1;
        key_ok <= 1'b0;
      end
      if (ser_done) blk_cnt <= blk_cnt + 1'b1;
    end
  end

  trivium_ks_serializer #(.WORD_W(WORD_W)) u_ser (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .load  (ser_load),
    .din   (core_Dout),
    .valid (ser_valid),
    .ready (bus.ks_ready),
    .data  (ser_data),
    .last  (ser_last),
    .done  (ser_done)
  );
endmodule

// File: tb/tb_trivium_ks_ctrl.sv
// Bench for trivium_ks_ctrl: behavioural Trivium core stub plus a command-level reference model.
module tb_trivium_ks_ctrl;
  localparam int WORD_W  = 32;
  localparam int TIMEOUT = 100;
  localparam int CNT_W   = 16;
  localparam int NW      = 128 / WORD_W;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  trivium_ks_ctrl_if #(.WORD_W(WORD_W)) bus();

  logic             busy, err;
  logic [CNT_W-1:0] blk_cnt;
  logic [79:0]      core_Kin, core_Din;
  logic             core_Krdy, core_Drdy, core_EncDec, core_EN;
  logic             core_BSY, core_Kvld, core_Dvld;
  logic [127:0]     core_Dout;

  trivium_ks_ctrl #(.WORD_W(WORD_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RSTn(RSTn), .bus(bus),
    .busy(busy), .err(err), .blk_cnt(blk_cnt),
    .core_Kin(core_Kin), .core_Din(core_Din),
    .core_Krdy(core_Krdy), .core_Drdy(core_Drdy),
    .core_EncDec(core_EncDec), .core_EN(core_EN),
    .core_BSY(core_BSY), .core_Kvld(core_Kvld),
    .core_Dvld(core_Dvld), .core_Dout(core_Dout)
  );

  // Trivium keystream: 288b state, 4*288 warm-up rounds, then 128 output bits (bit i = z_i).
  function automatic logic [127:0] trivium_ks(input logic [79:0] k, input logic [79:0] iv);
    logic [287:0] s;
    logic [127:0] z;
    logic t1, t2, t3;
    s = '0;
    z = '0;
    for (int i = 0; i < 80; i++) begin
      s[i]      = k[i];
      s[93 + i] = iv[i];
    end
    s[285] = 1'b1; s[286] = 1'b1; s[287] = 1'b1;
    for (int r = 0; r < 1152 + 128; r++) begin
      t1 = s[65] ^ s[92];
      t2 = s[161] ^ s[176];
      t3 = s[242] ^ s[287];
      if (r >= 1152) z[r - 1152] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[90] & s[91]) ^ s[170];
      t2 = t2 ^ (s[174] & s[175]) ^ s[263];
      t3 = t3 ^ (s[285] & s[286]) ^ s[68];
      s[92:0]    = {s[91:0], t3};
      s[176:93]  = {s[175:93], t1};
      s[287:177] = {s[286:177], t2};
    end
    return z;
  endfunction

  function automatic logic [79:0] rnd80();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0];
  endfunction

  // Core stub: block latency shortened from the real ~1283 cycles to keep the run brief.
  int          klat = 3, dlat = 40, kcnt, dcnt;
  bit          dvld_dead = 1'b0;
  logic [79:0] c_key, c_iv;
  always @(posedge CLK) begin
    core_Kvld <= 1'b0;
    core_Dvld <= 1'b0;
    if (!RSTn) begin
      kcnt <= 0; dcnt <= 0; core_BSY <= 1'b0;
      c_key <= '0; c_iv <= '0; core_Dout <= '0;
    end else begin
      if (core_Krdy) begin
        c_key <= core_Kin; kcnt <= klat; core_BSY <= 1'b1;
      end else if (kcnt > 0) begin
        if (kcnt == 1) begin core_Kvld <= 1'b1; core_BSY <= 1'b0; end
        kcnt <= kcnt - 1;
      end
      if (core_Drdy) begin
        c_iv <= core_Din; dcnt <= dlat; core_BSY <= 1'b1;
      end else if (dcnt > 0) begin
        if (dcnt == 1 && !dvld_dead) begin
          core_Dvld <= 1'b1; core_Dout <= trivium_ks(c_key, c_iv); core_BSY <= 1'b0;
        end
        if (dcnt > 1 || !dvld_dead) dcnt <= dcnt - 1;
      end
    end
  end

  int krdy_n = 0, drdy_n = 0;
  always @(negedge CLK) begin
    if (core_Krdy === 1'b1) krdy_n++;
    if (core_Drdy === 1'b1) drdy_n++;
  end

  // Reference model state (command level).
  logic [79:0]  m_key;
  bit           m_key_ok, m_need;
  int           m_blk;
  logic [127:0] m_exp;
  int           k0, d0;
  int           n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.ks_ready  = 1'b0;
    tick();
    chk("rst_cmd_ready", 128'(bus.cmd_ready), '0);
    chk("rst_busy",      128'(busy), '0);
    chk("rst_err",       128'(err), '0);
    chk("rst_blk_cnt",   128'(blk_cnt), '0);
    chk("rst_ks_valid",  128'(bus.ks_valid), '0);
    chk("rst_ks_last",   128'(bus.ks_last), '0);
    chk("rst_ks_data",   128'(bus.ks_data), '0);
    chk("rst_krdy",      128'({core_Krdy, core_Drdy, core_EN, core_EncDec}), '0);
    chk("rst_kin_din",   128'({core_Kin, core_Din}), '0);
    tick();
    RSTn = 1'b1;
    m_key_ok = 1'b0;
    m_blk = 0;
    tick();
    chk("rst_ready_rise", 128'(bus.cmd_ready), 128'(1));
  endtask

  // Hands one command over and returns on the cycle the IV load pulse is visible.
  task automatic issue_cmd(input bit rekey, input logic [79:0] key, input logic [79:0] iv);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    chk("cmd_ready_wait", 128'(bus.cmd_ready), 128'(1));
    bus.cmd_valid = 1'b1; bus.cmd_rekey = rekey; bus.cmd_key = key; bus.cmd_iv = iv;
    k0 = krdy_n; d0 = drdy_n;
    m_need = rekey || !m_key_ok;
    if (m_need) m_key = key;
    m_exp = trivium_ks(m_key, iv);
    tick();
    // Keep a garbage command asserted while busy; it must be ignored.
    bus.cmd_key = rnd80(); bus.cmd_iv = rnd80(); bus.cmd_rekey = 1'($urandom_range(0, 1));
    chk("accept_busy",  128'(busy), 128'(1));
    chk("accept_err",   128'(err), '0);
    chk("accept_ready", 128'(bus.cmd_ready), '0);
    n = 0;
    while (drdy_n == d0 && n < 200) begin tick(); n++; end
    bus.cmd_valid = 1'b0;
    chk("drdy_seen",   128'(drdy_n - d0), 128'(1));
    chk("krdy_pulses", 128'(krdy_n - k0), 128'(m_need));
    chk("core_Din",    128'(core_Din), 128'(iv));
    chk("core_Kin",    128'(core_Kin), 128'(key));
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low for 50 valid cycles then random.
  task automatic drain(input int mode);
    int w = 0, cyc = 0, nv = 0;
    bit hold = 1'b0, started = 1'b0, bubble = 1'b0, rdy;
    logic [WORD_W-1:0] held = '0;
    while (w < NW && cyc < 400) begin
      tick();
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (nv >= 50) ? 1'($urandom_range(0, 1)) : 1'b0;
      endcase
      bus.ks_ready = rdy;
      #1;
      if (bus.ks_valid) begin
        started = 1'b1;
        nv++;
        chk("drain_cmd_ready", 128'(bus.cmd_ready), '0);
        if (hold) chk("data_stable", 128'(bus.ks_data), 128'(held));
        if (rdy) begin
          chk($sformatf("word%0d", w), 128'(bus.ks_data), 128'(m_exp[w*WORD_W +: WORD_W]));
          chk($sformatf("last%0d", w), 128'(bus.ks_last), 128'(w == NW - 1));
          w++;
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          held = bus.ks_data;
        end
      end else if (started) begin
        bubble = 1'b1;
      end
      cyc++;
    end
    if (w < NW) chk("drain_timeout", 128'(w), 128'(NW));
    chk("no_bubble", 128'(bubble), '0);
    tick();
    bus.ks_ready = 1'b0;
    m_blk++;
    m_key_ok = 1'b1;
    chk("blk_cnt",     128'(blk_cnt), 128'(m_blk % (1 << CNT_W)));
    chk("done_busy",   128'(busy), '0);
    chk("done_ready",  128'(bus.cmd_ready), 128'(1));
    chk("done_valid",  128'(bus.ks_valid), '0);
    chk("drdy_once",   128'(drdy_n - d0), 128'(1));
    chk("krdy_total",  128'(krdy_n - k0), 128'(m_need));
  endtask

  // Expected: TIMEOUT+1 cycles in BUSY plus one ABORT cycle after the IV pulse.
  task automatic abort_cmd(input bit rekey, input logic [79:0] key, input logic [79:0] iv);
    int nb = 0;
    bit sawv = 1'b0;
    issue_cmd(rekey, key, iv);
    do begin
      tick();
      if (bus.ks_valid) sawv = 1'b1;
      if (busy) nb++;
    end while (busy && nb < 400);
    m_key_ok = 1'b0;
    chk("abort_len",   128'(nb), 128'(TIMEOUT + 2));
    chk("abort_err",   128'(err), 128'(1));
    chk("abort_no_ks", 128'(sawv), '0);
    chk("abort_blk",   128'(blk_cnt), 128'(m_blk % (1 << CNT_W)));
    chk("abort_ready", 128'(bus.cmd_ready), 128'(1));
  endtask

  initial begin
    int n;
    bus.cmd_valid = 1'b0; bus.cmd_rekey = 1'b0; bus.cmd_key = '0; bus.cmd_iv = '0;
    bus.ks_ready = 1'b0;
    do_reset();

    // Reference key 0x80..0, zero IV, fresh key load.
    issue_cmd(1'b1, 80'h8000_0000_0000_0000_0000, 80'h0);
    drain(0);
    // Reuse the loaded key with a new IV.
    issue_cmd(1'b0, rnd80(), 80'h0000_0000_0000_0000_0001);
    drain(1);

    for (int i = 0; i < 6; i++) begin
      klat = $urandom_range(1, 6);
      dlat = $urandom_range(5, 90);
      issue_cmd(1'($urandom_range(0, 1)), rnd80(), rnd80());
      drain($urandom_range(0, 2));
    end

    // Dvld on the same cycle the watchdog expires: block is still delivered.
    klat = 2; dlat = TIMEOUT;
    issue_cmd(1'b0, rnd80(), rnd80());
    drain(0);
    chk("dvld_wins_err", 128'(err), '0);

    // One cycle later the watchdog wins; the late Dvld lands in ABORT and is ignored.
    dlat = TIMEOUT + 1;
    abort_cmd(1'b0, rnd80(), rnd80());

    // Core that never completes.
    dlat = 30; dvld_dead = 1'b1;
    abort_cmd(1'b1, rnd80(), rnd80());
    dvld_dead = 1'b0;
    tick(); tick();
    chk("stray_dvld_valid", 128'(bus.ks_valid), '0);
    chk("stray_dvld_busy",  128'(busy), '0);

    // Abort dropped the key: rekey=0 must still load it; err clears on accept.
    issue_cmd(1'b0, rnd80(), rnd80());
    drain(2);

    // Reset while waiting on the core.
    dlat = 80;
    issue_cmd(1'b1, rnd80(), rnd80());
    repeat (10) tick();
    do_reset();

    // Key lost across reset: rekey=0 still issues Krdy.
    dlat = 20;
    issue_cmd(1'b0, rnd80(), rnd80());
    drain(1);

    // Reset while a block is waiting to be drained.
    issue_cmd(1'b1, rnd80(), rnd80());
    n = 0;
    while (bus.ks_valid !== 1'b1 && n < 200) begin tick(); n++; end
    chk("valid_before_rst", 128'(bus.ks_valid), 128'(1));
    do_reset();

    issue_cmd(1'b0, rnd80(), rnd80());
    drain(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
